// File: rtl/wb_pipe_regfile_pkg.sv
// Shared types and constants for the MEM/WB pipeline and general register file.
package wb_pipe_regfile_pkg;
  localparam int REG_NUM_DEF = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int REG_ADDR_W  = 5;

  typedef logic [DATA_W_DEF-1:0] reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_bus_t  ZERO_WORD     = '0;
  localparam logic      WRITE_ENABLE  = 1'b1;
  localparam logic      WRITE_DISABLE = 1'b0;
  localparam logic      READ_ENABLE   = 1'b1;
  localparam reg_addr_t NOP_REG_ADDR  = '0;

  typedef struct packed {
    logic      we;
    reg_addr_t waddr;
    reg_bus_t  wdata;
  } wb_req_t;

  localparam wb_req_t BUBBLE = '{we: WRITE_DISABLE, waddr: NOP_REG_ADDR, wdata: ZERO_WORD};
endpackage

// File: rtl/wb_pipe_regfile_regfile.sv
// 32x32 register file: WB commit write plus two combinational read ports.
// With WB_FWD_EN defined, reads bypass in-flight MEM/WB results.
module wb_pipe_regfile_regfile
  import wb_pipe_regfile_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [4:0]        wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
`ifdef WB_FWD_EN
  input  logic              mem_we,
  input  logic [4:0]        mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
`endif
  input  logic              re1,
  input  logic [4:0]        raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata2
);
  reg_bus_t regs_q [REG_NUM];
  reg_bus_t regs_d [REG_NUM];

  always_comb begin
    regs_d = regs_q;
    if (wb_we == WRITE_ENABLE && wb_waddr != NOP_REG_ADDR) regs_d[wb_waddr] = wb_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= ZERO_WORD;
    end else begin
      regs_q <= regs_d;
    end
  end

  // MEM is younger than WB, so its result wins when both target the same register.
  function automatic reg_bus_t rd_sel(input logic re, input reg_addr_t ra);
    if (re != READ_ENABLE)     return ZERO_WORD;
    if (ra == NOP_REG_ADDR)    return ZERO_WORD;
`ifdef WB_FWD_EN
    if (mem_we && mem_waddr == ra) return mem_wdata;
    if (wb_we  && wb_waddr  == ra) return wb_wdata;
`endif
    return regs_q[ra];
  endfunction

  always_comb begin
    rdata1 = rd_sel(re1, raddr1);
    rdata2 = rd_sel(re2, raddr2);
  end
endmodule

// File: rtl/wb_pipe_regfile.sv
// MEM and WB pipeline latches with stall/flush, feeding the register file.
// Optional bypass network enabled by macro WB_FWD_EN.
module wb_pipe_regfile
  import wb_pipe_regfile_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_we,
  input  logic [4:0]        ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              stall,
  input  logic              flush,
  input  logic              re1,
  input  logic [4:0]        raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              mem_we,
  output logic [4:0]        mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              wb_we,
  output logic [4:0]        wb_waddr,
  output logic [DATA_W-1:0] wb_wdata
);
  wb_req_t ex_req, mem_d, mem_q, wb_d, wb_q;

  assign ex_req = '{we: ex_we, waddr: ex_waddr, wdata: ex_wdata};

  // Flush overrides stall; under flush+stall WB still drains the old MEM entry.
  always_comb begin
    mem_d = mem_q;
    wb_d  = mem_q;
    if (flush)       mem_d = BUBBLE;
    else if (!stall) mem_d = ex_req;
    if (stall && !flush) wb_d = BUBBLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign mem_we    = mem_q.we;
  assign mem_waddr = mem_q.waddr;
  assign mem_wdata = mem_q.wdata;
  assign wb_we     = wb_q.we;
  assign wb_waddr  = wb_q.waddr;
  assign wb_wdata  = wb_q.wdata;

  wb_pipe_regfile_regfile #(.REG_NUM(REG_NUM), .DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wb_we    (wb_q.we),
    .wb_waddr (wb_q.waddr),
    .wb_wdata (wb_q.wdata),
`ifdef WB_FWD_EN
    .mem_we   (mem_q.we),
    .mem_waddr(mem_q.waddr),
    .mem_wdata(mem_q.wdata),
`endif
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (rdata2)
  );
endmodule

// File: tb/tb_wb_pipe_regfile.sv
// Directed table-driven bench for wb_pipe_regfile; expectations track WB_FWD_EN.
module tb_wb_pipe_regfile;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_we = 1'b0, stall = 1'b0, flush = 1'b0, re1 = 1'b0, re2 = 1'b0;
  logic [4:0]  ex_waddr = '0, raddr1 = '0, raddr2 = '0;
  logic [31:0] ex_wdata = '0;
  logic [31:0] rdata1, rdata2, mem_wdata, wb_wdata;
  logic        mem_we, wb_we;
  logic [4:0]  mem_waddr, wb_waddr;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_pipe_regfile dut (
    .clk(clk), .rst(rst),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .stall(stall), .flush(flush),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  typedef struct {
    logic        we;  logic [4:0] wa; logic [31:0] wd;
    logic        st;  logic fl;
    logic        re1; logic [4:0] a1; logic re2; logic [4:0] a2;
    logic [31:0] r1f, r1n, r2f, r2n;
    logic        mwe; logic [4:0] mwa; logic [31:0] mwd;
    logic        wwe; logic [4:0] wwa; logic [31:0] wwd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic st, input logic fl,
                     input logic r1e, input logic [4:0] a1, input logic r2e, input logic [4:0] a2,
                     input logic [31:0] r1f, input logic [31:0] r1n,
                     input logic [31:0] r2f, input logic [31:0] r2n,
                     input logic mwe, input logic [4:0] mwa, input logic [31:0] mwd,
                     input logic wwe, input logic [4:0] wwa, input logic [31:0] wwd);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.fl = fl;
    v.re1 = r1e; v.a1 = a1; v.re2 = r2e; v.a2 = a2;
    v.r1f = r1f; v.r1n = r1n; v.r2f = r2f; v.r2n = r2n;
    v.mwe = mwe; v.mwa = mwa; v.mwd = mwd; v.wwe = wwe; v.wwa = wwa; v.wwd = wwd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic st, input logic fl,
                       input logic r1e, input logic [4:0] a1, input logic r2e, input logic [4:0] a2);
    ex_we = we; ex_waddr = wa; ex_wdata = wd; stall = st; flush = fl;
    re1 = r1e; raddr1 = a1; re2 = r2e; raddr2 = a2;
  endtask

  initial begin
    // Rows are applied one per cycle; checks see state after the previous edge.
    //   ex we wa wd            st fl  re1 a1 re2 a2  r1f r1n r2f r2n                     mwe mwa mwd           wwe wwa wwd
    add(1, 3, 32'h12345678, 0, 0,  1, 3, 1, 5,  0, 0, 0, 0,                               0, 0, 0,              0, 0, 0);
    add(1, 7, 32'hA5A5A5A5, 0, 0,  1, 3, 1, 7,  32'h12345678, 0, 0, 0,                    1, 3, 32'h12345678,   0, 0, 0);
    add(0, 0, 0,            0, 0,  1, 7, 1, 3,  32'hA5A5A5A5, 0, 32'h12345678, 0,         1, 7, 32'hA5A5A5A5,   1, 3, 32'h12345678);
    add(0, 0, 0,            0, 0,  1, 3, 1, 7,  32'h12345678, 32'h12345678, 32'hA5A5A5A5, 0, 0, 0, 0,           1, 7, 32'hA5A5A5A5);
    add(1, 7, 1,            0, 0,  1, 7, 1, 3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h12345678, 32'h12345678, 0, 0, 0, 0, 0, 0);
    add(1, 7, 2,            0, 0,  1, 7, 1, 0,  1, 32'hA5A5A5A5, 0, 0,                   1, 7, 1,              0, 0, 0);
    add(0, 0, 0,            0, 0,  1, 7, 1, 7,  2, 32'hA5A5A5A5, 2, 32'hA5A5A5A5,         1, 7, 2,              1, 7, 1);
    add(1, 0, 32'hFFFFFFFF, 0, 0,  1, 7, 1, 0,  2, 1, 0, 0,                               0, 0, 0,              1, 7, 2);
    add(0, 0, 0,            0, 0,  1, 0, 1, 7,  0, 0, 2, 2,                               1, 0, 32'hFFFFFFFF,   0, 0, 0);
    add(0, 0, 0,            0, 0,  1, 0, 0, 7,  0, 0, 0, 0,                               0, 0, 0,              1, 0, 32'hFFFFFFFF);
    add(1, 4, 32'h55,       0, 0,  1, 4, 1, 0,  0, 0, 0, 0,                               0, 0, 0,              0, 0, 0);
    add(0, 0, 0,            1, 0,  1, 4, 1, 4,  32'h55, 0, 32'h55, 0,                     1, 4, 32'h55,         0, 0, 0);
    add(0, 0, 0,            0, 0,  1, 4, 1, 4,  32'h55, 0, 32'h55, 0,                     1, 4, 32'h55,         0, 0, 0);
    add(0, 0, 0,            0, 0,  1, 4, 1, 4,  32'h55, 0, 32'h55, 0,                     0, 0, 0,              1, 4, 32'h55);
    add(0, 0, 0,            0, 0,  1, 4, 1, 4,  32'h55, 32'h55, 32'h55, 32'h55,           0, 0, 0,              0, 0, 0);
    add(1, 4, 32'h99,       0, 1,  1, 4, 1, 4,  32'h55, 32'h55, 32'h55, 32'h55,           0, 0, 0,              0, 0, 0);
    add(0, 0, 0,            0, 0,  1, 4, 1, 4,  32'h55, 32'h55, 32'h55, 32'h55,           0, 0, 0,              0, 0, 0);
    add(0, 0, 0,            0, 0,  1, 4, 1, 4,  32'h55, 32'h55, 32'h55, 32'h55,           0, 0, 0,              0, 0, 0);
    add(1, 1, 32'h11,       0, 0,  1, 4, 1, 4,  32'h55, 32'h55, 32'h55, 32'h55,           0, 0, 0,              0, 0, 0);
    add(1, 2, 32'h22,       0, 0,  0, 4, 0, 4,  0, 0, 0, 0,                               1, 1, 32'h11,         0, 0, 0);
    add(0, 0, 0,            0, 0,  0, 4, 0, 4,  0, 0, 0, 0,                               1, 2, 32'h22,         1, 1, 32'h11);
    add(0, 0, 0,            0, 0,  0, 4, 0, 4,  0, 0, 0, 0,                               0, 0, 0,              1, 2, 32'h22);
    add(0, 0, 0,            0, 0,  1, 2, 1, 1,  32'h22, 32'h22, 32'h11, 32'h11,           0, 0, 0,              0, 0, 0);
    add(0, 0, 0,            0, 0,  1, 2, 0, 1,  32'h22, 32'h22, 0, 0,                     0, 0, 0,              0, 0, 0);
    add(1, 9, 32'h9,        0, 0,  1, 9, 0, 0,  0, 0, 0, 0,                               0, 0, 0,              0, 0, 0);
    add(0, 0, 0,            1, 1,  1, 9, 0, 0,  32'h9, 0, 0, 0,                           1, 9, 32'h9,          0, 0, 0);
    add(0, 0, 0,            0, 0,  1, 9, 0, 0,  32'h9, 0, 0, 0,                           0, 0, 0,              1, 9, 32'h9);
    add(0, 0, 0,            0, 0,  1, 9, 1, 9,  32'h9, 32'h9, 32'h9, 32'h9,               0, 0, 0,              0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 5, 1, 9);
    #1;
    chk("rst_mem_we", 0, {31'd0, mem_we}, 0);
    chk("rst_wb_we", 0, {31'd0, wb_we}, 0);
    chk("rst_rdata1", 0, rdata1, 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].st, vecs[i].fl,
            vecs[i].re1, vecs[i].a1, vecs[i].re2, vecs[i].a2);
      #1;
      chk("rdata1", i, rdata1, FWD ? vecs[i].r1f : vecs[i].r1n);
      chk("rdata2", i, rdata2, FWD ? vecs[i].r2f : vecs[i].r2n);
      chk("mem_we", i, {31'd0, mem_we}, {31'd0, vecs[i].mwe});
      chk("mem_waddr", i, {27'd0, mem_waddr}, {27'd0, vecs[i].mwa});
      chk("mem_wdata", i, mem_wdata, vecs[i].mwd);
      chk("wb_we", i, {31'd0, wb_we}, {31'd0, vecs[i].wwe});
      chk("wb_waddr", i, {27'd0, wb_waddr}, {27'd0, vecs[i].wwa});
      chk("wb_wdata", i, wb_wdata, vecs[i].wwd);
    end

    // Reset mid-stream: r10 in flight is dropped, array (r9) clears asynchronously.
    @(negedge clk);
    drive(1, 10, 32'hAB, 0, 0, 1, 9, 1, 10);
    @(negedge clk);
    drive(1, 11, 32'hCD, 0, 0, 1, 9, 1, 10);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_mem_we", 0, {31'd0, mem_we}, 0);
    chk("mrst_mem_wdata", 0, mem_wdata, 0);
    chk("mrst_wb_we", 0, {31'd0, wb_we}, 0);
    chk("mrst_wb_wdata", 0, wb_wdata, 0);
    chk("mrst_r9", 0, rdata1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 10, 1, 11);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("mrst_r10", 0, rdata1, 0);
    chk("mrst_r11", 0, rdata2, 0);
    drive(0, 0, 0, 0, 0, 1, 5, 1, 3);
    #1;
    chk("mrst_r5", 0, rdata1, 0);
    chk("mrst_r3", 0, rdata2, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
